// File: rtl/score_pkg.sv
// Shared types, constants and saturating arithmetic for the score controller.
package score_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PLAY  = 3'd1,
    FLUSH = 3'd2,
    BEST  = 3'd3,
    OVER  = 3'd4
  } game_state_t;

  localparam int SCORE_W       = 7;
  localparam int DEF_MAX_SCORE = 99;

  // 8-bit sum cannot wrap for two 7-bit operands, so clamping it is exact.
  function automatic logic [SCORE_W-1:0] sat_add(input logic [7:0] a,
                                                 input logic [7:0] b,
                                                 input logic [7:0] max);
    logic [7:0] sum;
    sum = a + b;
    return (sum > max) ? max[SCORE_W-1:0] : sum[SCORE_W-1:0];
  endfunction

endpackage

// File: rtl/score_ctrl_if.sv
// Game events in, committed scores and display digits out.
interface score_ctrl_if;
  import score_pkg::*;

  logic               start;
  logic               game_over;
  logic               pass1;
  logic               pass2;
  logic               frame_start;
  logic [SCORE_W-1:0] score1;
  logic [SCORE_W-1:0] score2;
  logic [3:0]         disp_ones;
  logic [3:0]         disp_tens;
  logic               tens_valid;
  logic [SCORE_W-1:0] best;
  logic               new_best;
  logic [2:0]         state;

  // Game logic / bench side: drives events, observes scores.
  modport master (
    output start, game_over, pass1, pass2, frame_start,
    input  score1, score2, disp_ones, disp_tens, tens_valid, best, new_best, state
  );

  // Score controller side.
  modport slave (
    input  start, game_over, pass1, pass2, frame_start,
    output score1, score2, disp_ones, disp_tens, tens_valid, best, new_best, state
  );
endinterface

// File: rtl/score_digits.sv
// Registered split of a 0..99 total into ones/tens digits for the overlay.
module score_digits
  import score_pkg::*;
(
  input  logic               Clk,
  input  logic               Reset,
  input  logic [SCORE_W-1:0] total,
  output logic [3:0]         ones,
  output logic [3:0]         tens,
  output logic               tens_valid
);

  logic [3:0] ones_d, tens_d;
  logic       tens_valid_d;

  // Constant divide/modulo; total is pre-clamped so both digits fit in 4 bits.
  always_comb begin
    ones_d       = 4'(total % 10);
    tens_d       = 4'(total / 10);
    tens_valid_d = (total >= 7'd10);
  end

  // Digit registers: one cycle behind the score registers.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      ones       <= '0;
      tens       <= '0;
      tens_valid <= 1'b0;
    end else begin
      ones       <= ones_d;
      tens       <= tens_d;
      tens_valid <= tens_valid_d;
    end
  end

endmodule

// File: rtl/score_ctrl.sv
// Game flow sequencer with frame-aligned score commits and session best.
module score_ctrl
  import score_pkg::*;
#(
  parameter int MAX_SCORE = DEF_MAX_SCORE,
  parameter int PEND_W    = 3
) (
  input  logic         Clk,
  input  logic         Reset,
  score_ctrl_if.slave  bus
);

  localparam logic [7:0]        MAX_8    = 8'(MAX_SCORE);
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  game_state_t        state_q, state_d;
  logic [SCORE_W-1:0] score1_q, score1_d;
  logic [SCORE_W-1:0] score2_q, score2_d;
  logic [SCORE_W-1:0] best_q, best_d;
  logic [PEND_W-1:0]  pend1_q, pend1_d;
  logic [PEND_W-1:0]  pend2_q, pend2_d;
  logic               new_best_q, new_best_d;
  logic [SCORE_W-1:0] total_c;

  function automatic logic [PEND_W-1:0] pend_inc(input logic [PEND_W-1:0] p,
                                                 input logic pulse);
    return (pulse && (p != PEND_MAX)) ? p + 1'b1 : p;
  endfunction

  // Displayed total is always derived from the committed scores.
  assign total_c = sat_add({1'b0, score1_q}, {1'b0, score2_q}, MAX_8);

  // Next-state and datapath decisions for the game flow.
  always_comb begin
    // NOTE: every _d starts at its _q so no path through the case leaves a
    // variable unassigned; that is what keeps this block latch-free.
    state_d    = state_q;
    score1_d   = score1_q;
    score2_d   = score2_q;
    best_d     = best_q;
    pend1_d    = pend1_q;
    pend2_d    = pend2_q;
    new_best_d = new_best_q;

    case (state_q)
      IDLE, OVER: begin
        if (bus.start) begin
          state_d    = PLAY;
          score1_d   = '0;
          score2_d   = '0;
          pend1_d    = '0;
          pend2_d    = '0;
          new_best_d = 1'b0;
        end
      end
      PLAY: begin
        if (bus.game_over) begin
          state_d = FLUSH;
          pend1_d = pend_inc(pend1_q, bus.pass1);
          pend2_d = pend_inc(pend2_q, bus.pass2);
        end else if (bus.frame_start) begin
          // A pass on the commit edge seeds the next frame instead of being lost.
          score1_d = sat_add({1'b0, score1_q}, 8'(pend1_q), MAX_8);
          score2_d = sat_add({1'b0, score2_q}, 8'(pend2_q), MAX_8);
          pend1_d  = PEND_W'(bus.pass1);
          pend2_d  = PEND_W'(bus.pass2);
        end else begin
          pend1_d = pend_inc(pend1_q, bus.pass1);
          pend2_d = pend_inc(pend2_q, bus.pass2);
        end
      end
      FLUSH: begin
        score1_d = sat_add({1'b0, score1_q}, 8'(pend1_q), MAX_8);
        score2_d = sat_add({1'b0, score2_q}, 8'(pend2_q), MAX_8);
        pend1_d  = '0;
        pend2_d  = '0;
        state_d  = BEST;
      end
      BEST: begin
        // Strictly greater: a tie keeps the old best and does not flag it.
        if (total_c > best_q) begin
          best_d     = total_c;
          new_best_d = 1'b1;
        end
        state_d = OVER;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset acts immediately, even mid-game.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= IDLE;
      score1_q   <= '0;
      score2_q   <= '0;
      best_q     <= '0;
      pend1_q    <= '0;
      pend2_q    <= '0;
      new_best_q <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge values together.
      state_q    <= state_d;
      score1_q   <= score1_d;
      score2_q   <= score2_d;
      best_q     <= best_d;
      pend1_q    <= pend1_d;
      pend2_q    <= pend2_d;
      new_best_q <= new_best_d;
    end
  end

  score_digits u_digits (
    .Clk        (Clk),
    .Reset      (Reset),
    .total      (total_c),
    .ones       (bus.disp_ones),
    .tens       (bus.disp_tens),
    .tens_valid (bus.tens_valid)
  );

  assign bus.score1   = score1_q;
  assign bus.score2   = score2_q;
  assign bus.best     = best_q;
  assign bus.new_best = new_best_q;
  assign bus.state    = state_q;

endmodule

// File: tb/tb_score_ctrl.sv
// Self-checking bench: directed scenarios plus random events vs a score model.
module tb_score_ctrl;
  import score_pkg::*;

  localparam int MAXS = 99;
  localparam int PMAX = 7;

  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  score_ctrl_if sif ();

  score_ctrl #(.MAX_SCORE(MAXS), .PEND_W(3)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (sif)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: plain integers following the game rules.
  game_state_t m_state;
  int m_s1, m_s2, m_p1, m_p2, m_best, m_nb, m_dtot;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic model_reset();
    m_state = IDLE;
    m_s1 = 0; m_s2 = 0; m_p1 = 0; m_p2 = 0;
    m_best = 0; m_nb = 0; m_dtot = 0;
  endtask

  task automatic new_game();
    m_state = PLAY;
    m_s1 = 0; m_s2 = 0; m_p1 = 0; m_p2 = 0; m_nb = 0;
  endtask

  task automatic model_edge(input bit st, input bit go, input bit p1,
                            input bit p2, input bit fs);
    int t;
    m_dtot = imin(m_s1 + m_s2, MAXS);
    case (m_state)
      IDLE, OVER: if (st) new_game();
      PLAY: begin
        if (!go && fs) begin
          m_s1 = imin(m_s1 + m_p1, MAXS);
          m_s2 = imin(m_s2 + m_p2, MAXS);
          m_p1 = int'(p1);
          m_p2 = int'(p2);
        end else begin
          m_p1 = imin(m_p1 + int'(p1), PMAX);
          m_p2 = imin(m_p2 + int'(p2), PMAX);
          if (go) m_state = FLUSH;
        end
      end
      FLUSH: begin
        m_s1 = imin(m_s1 + m_p1, MAXS);
        m_s2 = imin(m_s2 + m_p2, MAXS);
        m_p1 = 0; m_p2 = 0;
        m_state = BEST;
      end
      BEST: begin
        t = imin(m_s1 + m_s2, MAXS);
        if (t > m_best) begin
          m_best = t;
          m_nb   = 1;
        end
        m_state = OVER;
      end
      default: m_state = IDLE;
    endcase
  endtask

  task automatic check_all(input string tag);
    check({tag, ".state"},    32'(sif.state),      32'(m_state));
    check({tag, ".score1"},   32'(sif.score1),     32'(m_s1));
    check({tag, ".score2"},   32'(sif.score2),     32'(m_s2));
    check({tag, ".best"},     32'(sif.best),       32'(m_best));
    check({tag, ".new_best"}, 32'(sif.new_best),   32'(m_nb));
    check({tag, ".ones"},     32'(sif.disp_ones),  32'(m_dtot % 10));
    check({tag, ".tens"},     32'(sif.disp_tens),  32'(m_dtot / 10));
    check({tag, ".tens_v"},   32'(sif.tens_valid), 32'(m_dtot >= 10));
  endtask

  // One clock: drive on the falling edge, compare 1 time unit after the rising edge.
  task automatic step(input string tag, input bit st, input bit go,
                      input bit p1, input bit p2, input bit fs);
    @(negedge Clk);
    sif.start = st; sif.game_over = go; sif.pass1 = p1;
    sif.pass2 = p2; sif.frame_start = fs;
    @(posedge Clk);
    model_edge(st, go, p1, p2, fs);
    #1;
    check_all(tag);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, 0, 0, 0, 0, 0);
  endtask

  task automatic passes(input string tag, input int n1, input int n2);
    for (int i = 0; i < imin(n1, n2); i++) step(tag, 0, 0, 1, 1, 0);
    for (int i = n2; i < n1; i++) step(tag, 0, 0, 1, 0, 0);
    for (int i = n1; i < n2; i++) step(tag, 0, 0, 0, 1, 0);
  endtask

  task automatic end_game(input string tag);
    step(tag, 0, 1, 0, 0, 0);
    idle(tag, 3);
  endtask

  initial begin
    sif.start = 0; sif.game_over = 0; sif.pass1 = 0;
    sif.pass2 = 0; sif.frame_start = 0;
    Reset = 1'b1;
    model_reset();
    #12;
    check_all("por");
    @(negedge Clk);
    Reset = 1'b0;

    // Reset mid-PLAY with score1=5, pend2=3.
    step("rst_a", 1, 0, 0, 0, 0);
    passes("rst_a", 5, 0);
    step("rst_a", 0, 0, 0, 0, 1);
    passes("rst_a", 0, 3);
    check("rst_pre.score1", 32'(sif.score1), 32'd5);
    @(negedge Clk);
    #2;
    Reset = 1'b1;
    #1;
    model_reset();
    check_all("rst_async");
    @(negedge Clk);
    Reset = 1'b0;
    step("rst_fs", 0, 0, 0, 0, 1);
    check("rst_fs.state", 32'(sif.state), 32'(IDLE));

    // Basic frame-aligned commit: 3 + 2 passes, then frame_start.
    step("basic", 1, 0, 0, 0, 0);
    passes("basic", 3, 2);
    check("basic.pre_s1", 32'(sif.score1), 32'd0);
    step("basic", 0, 0, 0, 0, 1);
    check("basic.s1", 32'(sif.score1), 32'd3);
    check("basic.s2", 32'(sif.score2), 32'd2);
    step("basic_d", 0, 0, 0, 0, 0);
    check("basic.ones", 32'(sif.disp_ones), 32'd5);
    check("basic.tv",   32'(sif.tens_valid), 32'd0);

    // Pass coincident with commit carries into the next frame.
    passes("coin", 2, 0);
    step("coin", 0, 0, 1, 0, 1);
    check("coin.s1a", 32'(sif.score1), 32'd5);
    step("coin", 0, 0, 0, 0, 1);
    check("coin.s1b", 32'(sif.score1), 32'd6);
    end_game("coin_end");

    // Pending saturation and score ceiling.
    step("sat", 1, 0, 0, 0, 0);
    passes("sat", 9, 0);
    step("sat", 0, 0, 0, 0, 1);
    check("sat.pend7", 32'(sif.score1), 32'd7);
    for (int f = 0; f < 12; f++) begin
      passes("sat", 7, 0);
      step("sat", 0, 0, 0, 0, 1);
    end
    passes("sat", 6, 0);
    step("sat", 0, 0, 0, 0, 1);
    check("sat.s97", 32'(sif.score1), 32'd97);
    passes("sat", 5, 5);
    step("sat", 0, 0, 0, 0, 1);
    check("sat.s99", 32'(sif.score1), 32'd99);
    check("sat.s2",  32'(sif.score2), 32'd5);
    step("sat_d", 0, 0, 0, 0, 0);
    check("sat.tens", 32'(sif.disp_tens), 32'd9);
    check("sat.ones", 32'(sif.disp_ones), 32'd9);
    end_game("sat_end");

    // Fresh session for the best-score sequence: best=10 first.
    @(negedge Clk);
    Reset = 1'b1;
    #1;
    model_reset();
    @(negedge Clk);
    Reset = 1'b0;
    step("b10", 1, 0, 0, 0, 0);
    passes("b10", 5, 5);
    step("b10", 0, 0, 0, 0, 1);
    end_game("b10_end");
    check("b10.best", 32'(sif.best), 32'd10);

    // 6/6 committed, pend1=1, game_over with start and frame_start.
    step("go", 1, 0, 0, 0, 0);
    passes("go", 6, 6);
    step("go", 0, 0, 0, 0, 1);
    step("go", 0, 0, 1, 0, 0);
    step("go_n", 1, 1, 0, 0, 1);
    check("go.n_state", 32'(sif.state), 32'(FLUSH));
    step("go_n1", 1, 0, 0, 0, 0);
    check("go.n1_state", 32'(sif.state), 32'(BEST));
    check("go.n1_s1",    32'(sif.score1), 32'd7);
    step("go_n2", 0, 0, 0, 0, 0);
    check("go.n2_state", 32'(sif.state), 32'(OVER));
    check("go.n2_best",  32'(sif.best), 32'd13);
    check("go.n2_nb",    32'(sif.new_best), 32'd1);

    // Tie game: total 13 again.
    step("tie", 1, 0, 0, 0, 0);
    passes("tie", 7, 0);
    step("tie", 0, 0, 0, 0, 1);
    passes("tie", 0, 6);
    step("tie", 0, 0, 0, 0, 1);
    end_game("tie_end");
    check("tie.nb",   32'(sif.new_best), 32'd0);
    check("tie.best", 32'(sif.best), 32'd13);
    passes("over", 3, 2);
    step("over", 0, 0, 0, 0, 1);
    check("over.s1", 32'(sif.score1), 32'd7);
    step("restart", 1, 0, 0, 0, 0);
    check("restart.state", 32'(sif.state), 32'(PLAY));
    check("restart.s1",    32'(sif.score1), 32'd0);
    check("restart.best",  32'(sif.best), 32'd13);

    // Random event mix against the model.
    for (int i = 0; i < 4000; i++) begin
      step("rnd",
           $urandom_range(0, 99) < 4,
           $urandom_range(0, 99) < 2,
           $urandom_range(0, 99) < 40,
           $urandom_range(0, 99) < 35,
           $urandom_range(0, 99) < 8);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/score_ctrl.md
Name: score_ctrl

Overview:
- Game-level scoring controller that drives the score overlay renderer.
- Collects per-bird pipe-pass pulses and commits them to the score registers only at frame start, so the overlay never tears mid-frame.
- Sequences the IDLE/PLAY/game-over flow and keeps a session best score.
- Provides registered score1/score2 and pre-split display digits (ones, tens, tens-visible) to the overlay and sprite-address logic.

Parameters:
- MAX_SCORE, 99: saturation ceiling for each score and for the combined total; must be ≤ 99 so the display needs two digits.
- PEND_W, 3: width of each pending-pass counter; saturates at 2^PEND_W-1.

Ports:
- Clk  in  1  system clock
- Reset  in  1  asynchronous, active-high reset
- start  in  1  single-cycle start/restart request
- game_over  in  1  single-cycle collision/game-over event
- pass1  in  1  single-cycle pulse: bird 1 cleared a pipe
- pass2  in  1  single-cycle pulse: bird 2 cleared a pipe
- frame_start  in  1  single-cycle pulse at the first pixel of a frame (DrawX=0, DrawY=0)
- score1  out  7  committed score, bird 1
- score2  out  7  committed score, bird 2
- disp_ones  out  4  ones digit of the saturated total
- disp_tens  out  4  tens digit of the saturated total
- tens_valid  out  1  high when total ≥ 10 (tens digit is drawn)
- best  out  7  highest total seen since Reset
- new_best  out  1  high from the end of the last game until the next start, when that game set a new best
- state  out  3  current game_state_t, for the game FSM and debug

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-game): state=IDLE; score1, score2, pend1, pend2, best, disp_ones, disp_tens all 0; tens_valid=0; new_best=0.
- best is cleared only by Reset.
- States: IDLE, PLAY, FLUSH, BEST, OVER.
- IDLE:
  - pass1, pass2, game_over and frame_start are ignored.
  - start → PLAY. On that same edge, clear score1, score2, pend1, pend2 and new_best.
- PLAY:
  - pass1 increments pend1 and pass2 increments pend2; each saturates at 2^PEND_W-1.
  - On frame_start: score1 ← min(score1+pend1, MAX_SCORE), and likewise for score2.
  - On that same frame_start edge, pend ← 1 if the pass pulse is also high, else 0. A pass coinciding with a commit therefore lands in the next frame and is never lost.
  - start is ignored.
  - game_over → FLUSH. game_over has priority over start and frame_start on the same cycle. pass pulses on that cycle are still added to pending.
- FLUSH (1 cycle):
  - Commit pend1/pend2 to the scores with saturation, independent of frame_start.
  - Clear both pending counters, then → BEST.
  - All inputs ignored.
- BEST (1 cycle):
  - total = min(score1+score2, MAX_SCORE).
  - If total > best: best ← total and new_best ← 1. A tie does not set new_best.
  - → OVER.
- OVER:
  - Scores are frozen; passes and frame_start are ignored.
  - start → PLAY, with the same clears as from IDLE.
- Timing: with game_over sampled at edge N, the final scores are visible after edge N+1, best/new_best after edge N+2, and state=OVER after edge N+2.
- Display path:
  - total is recomputed from the score registers each cycle.
  - disp_ones, disp_tens and tens_valid are registered, so they lag the score registers by exactly 1 cycle.
  - For total=0: digits 0/0, tens_valid=0.
  - Values above MAX_SCORE are never presented.
- Arithmetic: all sums use 8-bit intermediates before saturation, so there is no wrap-around. Scores never exceed MAX_SCORE.

Decomposition:
- Package score_pkg holds:
  - typedef enum game_state_t {IDLE, PLAY, FLUSH, BEST, OVER}
  - localparam SCORE_W=7
  - localparam DEF_MAX_SCORE=99
  - function sat_add(a, b, max)
- Sub-module score_digits: registered binary-to-two-digit splitter.
  - Inputs: Clk, Reset, total.
  - Outputs: ones, tens, tens_valid.
  - score_ctrl instantiates one copy.

Test Plan:
- Reset mid-PLAY with score1=5 and pend2=3 → all outputs 0 and state=IDLE within the same cycle; a following frame_start changes nothing.
- start, then 3 pass1 pulses and 2 pass2 pulses, then frame_start → score1=3, score2=2; one cycle later disp_ones=5, disp_tens=0, tens_valid=0. Before frame_start, scores stay 0.
- pass1 on the same cycle as frame_start with pend1=2 → score1 +2 at that edge, pend1=1; the next frame_start gives score1 +1 more.
- 9 pass1 pulses within one frame (PEND_W=3) → pend1 saturates at 7 and score1 +7. Separately, drive score1=97 with 5 more passes → score1=99; total clamps to 99, disp_tens=9, disp_ones=9.
- PLAY with committed score1=6, score2=6, pend1=1, best=10; game_over together with start and frame_start → FLUSH, BEST, OVER over three edges. Final score1=7; best=13 at N+2; new_best=1; start ignored.
- Second game ends with total=13 (tie) → new_best=0 and best stays 13. In OVER, pass1 pulses leave the scores unchanged. start → PLAY with scores 0 and best still 13.
